// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter: bus registers, TX FIFO, 8N1 serialiser.
// Register index comes from addr[3:2]: TXDATA, STATUS, DIV, reserved.
module bus_uart_tx #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd217
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        ren,
    output logic [31:0] rdata,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [1:0]  wsize,
    output logic        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   div;

    state_t        state, state_n;
    logic [15:0]   timer, timer_n;
    logic [15:0]   fdiv, fdiv_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic          pop;

    logic          empty, full, busy;
    logic          wr_sel, rd_sel, push_req, push, last;
    logic [1:0]    idx;
    logic [15:0]   div_eff;
    logic          unused_bits;

    assign idx      = addr[3:2];
    assign wr_sel   = sel & wen;
    assign rd_sel   = sel & ren;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign busy     = (state != IDLE);
    assign push_req = wr_sel && (idx == 2'd0);
    assign push     = push_req && (!full || pop);
    assign div_eff  = (div == 16'd0) ? 16'd1 : div;
    assign last     = (timer == 16'd1);

    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16], wsize};

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag and baud divisor register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
            div      <= DEFAULT_DIV;
        end else begin
            if (push_req && full && !pop)
                overflow <= 1'b1;
            else if (wr_sel && idx == 2'd1 && wdata[3])
                overflow <= 1'b0;
            if (wr_sel && idx == 2'd2)
                div <= wdata[15:0];
        end
    end

    // Registered read port, sampling pre-edge state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (rd_sel) begin
            case (idx)
                2'd1:    rdata <= {20'b0, 4'(count), 4'b0,
                                   overflow, busy, full, empty};
                2'd2:    rdata <= {16'b0, div};
                default: rdata <= '0;
            endcase
        end
    end

    // Serialiser state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            timer  <= 16'd1;
            fdiv   <= 16'd1;
            bitcnt <= '0;
            shreg  <= '0;
            tx     <= 1'b1;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            fdiv   <= fdiv_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            tx     <= tx_n;
        end
    end

    // Serialiser next state: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        fdiv_n   = fdiv;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        tx_n     = tx;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = mem[rptr];
                    fdiv_n  = div_eff;
                    timer_n = div_eff;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (last) begin
                    tx_n     = shreg[0];
                    shreg_n  = shreg >> 1;
                    bitcnt_n = 3'd0;
                    timer_n  = fdiv;
                    state_n  = DATA;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            DATA: begin
                if (last) begin
                    timer_n = fdiv;
                    if (bitcnt == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        tx_n     = shreg[0];
                        shreg_n  = shreg >> 1;
                        bitcnt_n = bitcnt + 3'd1;
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            STOP: begin
                if (last) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = mem[rptr];
                        fdiv_n  = div_eff;
                        timer_n = div_eff;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Bench for bus_uart_tx: queue-based frame model checked every cycle,
// plus directed register reads and hand-derived tx waveforms.
module tb_bus_uart_tx;

    localparam int DEPTH = 8;

    logic        clk;
    logic        resetn;
    logic        sel;
    logic [31:0] addr;
    logic        ren;
    logic [31:0] rdata;
    logic        wen;
    logic [31:0] wdata;
    logic [1:0]  wsize;
    logic        tx;

    int checks = 0;
    int errors = 0;
    bit en_cmp = 0;

    bus_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd217)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sel    (sel),
        .addr   (addr),
        .ren    (ren),
        .rdata  (rdata),
        .wen    (wen),
        .wdata  (wdata),
        .wsize  (wsize),
        .tx     (tx)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: a queue of bytes and a frame position counter
    logic [7:0]  q[$];
    logic [7:0]  m_log[$];
    bit          m_ovf;
    int          m_div;
    bit          m_active;
    int          m_pos;
    int          m_fdiv;
    logic [7:0]  m_byte;
    logic [31:0] m_rdata;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [31:0] v;
        logic [3:0]  c;
        v = 0;
        c = 4'(q.size());
        if (a == 2'd1)
            v = {20'b0, c, 4'b0, m_ovf, m_active,
                 q.size() == DEPTH, q.size() == 0};
        else if (a == 2'd2)
            v = {16'b0, 16'(m_div)};
        return v;
    endfunction

    function automatic logic m_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / m_fdiv;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    always @(posedge clk or negedge resetn) begin
        int  n;
        bit  popd;
        if (!resetn) begin
            q.delete();
            m_ovf    = 0;
            m_div    = 217;
            m_active = 0;
            m_pos    = 0;
            m_fdiv   = 1;
            m_byte   = 0;
            m_rdata  = 0;
        end else begin
            n    = q.size();
            popd = 0;
            if (sel && ren) m_rdata = m_read(addr[3:2]);
            if (m_active && m_pos != 10*m_fdiv-1) begin
                m_pos++;
            end else if (n > 0) begin
                m_byte   = q.pop_front();
                m_fdiv   = (m_div == 0) ? 1 : m_div;
                m_pos    = 0;
                m_active = 1;
                popd     = 1;
                m_log.push_back(m_byte);
            end else begin
                m_active = 0;
            end
            if (sel && wen && addr[3:2] == 2'd0) begin
                if (n < DEPTH || popd) q.push_back(wdata[7:0]);
                else m_ovf = 1;
            end
            if (sel && wen && addr[3:2] == 2'd1 && wdata[3]) m_ovf = 0;
            if (sel && wen && addr[3:2] == 2'd2) m_div = int'(wdata[15:0]);
        end
    end

    // Every cycle out of reset: tx and rdata must match the model
    always @(negedge clk) begin
        if (en_cmp && resetn) begin
            checks++;
            if (tx !== m_tx()) begin
                errors++;
                $display("FAIL tx_model t=%0t got %b want %b",
                         $time, tx, m_tx());
            end
            checks++;
            if (rdata !== m_rdata) begin
                errors++;
                $display("FAIL rdata_model t=%0t got %h want %h",
                         $time, rdata, m_rdata);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    // Bus tasks: called at a negedge, return at the following negedge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = 32'h40001000 | {28'b0, a, 2'b00};
        wdata = d;
        sel   = 1;
        wen   = 1;
        @(negedge clk);
        sel = 0;
        wen = 0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = 32'h40001000 | {28'b0, a, 2'b00};
        sel  = 1;
        ren  = 1;
        @(negedge clk);
        sel = 0;
        ren = 0;
        d   = rdata;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic [31:0] v;
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            rd(2'd1, v);
            if (v == 32'h1) done = 1;
        end
        chk(name, {63'b0, done}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [39:0] cap40;
        logic [39:0] exp40;
        logic [3:0]  cap4;
        int          zeros;

        sel = 0; ren = 0; wen = 0;
        addr = 0; wdata = 0; wsize = 2'b11;
        resetn = 0;
        repeat (3) @(negedge clk);
        resetn = 1;
        en_cmp = 1;

        chk("reset_tx", {63'b0, tx}, 64'd1);
        rd(2'd1, v); chk("reset_status", v, 64'h1);
        rd(2'd2, v); chk("reset_div", v, 64'hD9);
        rd(2'd3, v); chk("reserved_rd", v, 64'h0);

        // Single byte 0x55 at div 4
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h55);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            cap40[40-k] = tx;
        end
        exp40 = 40'b0000_1111_0000_1111_0000_1111_0000_1111_0000_1111;
        chk("frame_55", {24'b0, cap40}, {24'b0, exp40});
        rd(2'd1, v); chk("status_in_stop", v, 64'h5);
        rd(2'd1, v); chk("status_after", v, 64'h1);

        // Back-to-back frames at div 2
        wr(2'd2, 32'd2);
        wr(2'd0, 32'hA5);
        wr(2'd0, 32'h0F);
        rd(2'd1, v); chk("status_b2b", v, 64'h104);
        wait_idle("b2b_idle", 100);

        // Overflow at div 100
        m_log.delete();
        wr(2'd2, 32'd100);
        for (int i = 0; i < 10; i++) wr(2'd0, 32'(i));
        rd(2'd1, v); chk("status_ovf", v, 64'h80E);
        wr(2'd1, 32'h8);
        rd(2'd1, v); chk("status_ovf_clr", v, 64'h806);
        wait_idle("ovf_idle", 12000);
        chk("log_len", 64'(m_log.size()), 64'd9);
        for (int i = 0; i < m_log.size(); i++)
            chk("log_byte", {56'b0, m_log[i]}, 64'(i));

        // Divisor 0 behaves as 1; mid-frame divisor change
        wr(2'd2, 32'd0);
        rd(2'd2, v); chk("div_zero_rd", v, 64'h0);
        wr(2'd0, 32'h3C);
        wr(2'd0, 32'hC3);
        wr(2'd2, 32'd8);
        for (int k = 3; k <= 19; k++) begin
            @(negedge clk);
            if (k == 10) cap4[3] = tx;
            if (k == 11) cap4[2] = tx;
            if (k == 18) cap4[1] = tx;
            if (k == 19) cap4[0] = tx;
        end
        chk("div_change", {60'b0, cap4}, 64'b1001);
        wait_idle("div_idle", 200);

        // Reset during data bit 3
        wr(2'd2, 32'd4);
        wr(2'd0, 32'hF0);
        wr(2'd0, 32'h11);
        wr(2'd0, 32'h22);
        repeat (16) @(negedge clk);
        chk("bit3_low", {63'b0, tx}, 64'd0);
        resetn = 0;
        #1;
        chk("async_tx", {63'b0, tx}, 64'd1);
        @(negedge clk);
        resetn = 1;
        rd(2'd1, v); chk("status_post_rst", v, 64'h1);
        zeros = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx == 1'b0) zeros++;
        end
        chk("no_frame_post_rst", 64'(zeros), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
